countdown_timer: RTL and testbench
==================================

# countdown_timer

Down-counting counterpart of the watch controller's stopwatch: loads a preset time in BCD (M:SS.t, maximum 9:59.9) and counts it down to 0:00.0 one tenth-second tick at a time. When the count reaches zero it raises a done level and a one-cycle alarm pulse. It sits beside the stopwatch in the watch controller and feeds the same display mux, using the same four-digit output format. The tenth-second tick comes from an internal clock-enable prescaler, not from derived clocks.

## Interface
- TICK_DIV, default 1: number of `clk` cycles per tenth-second tick while running; legal range is 1 and above.
- clk  input  1  system clock; every register uses its rising edge only.
- reset  input  1  synchronous, active-low reset.
- load  input  1  preset strobe; captures the four set_* digits.
- set_min0, set_sec1, set_sec0, set_milSec0  input  4 each  preset digits in BCD.
- start_resume  input  1  start or resume the countdown; in DONE it re-arms the timer.
- stop  input  1  pause the countdown.
- min0, sec1, sec0, milSec0  output  4 each  current count in BCD.
- running  output  1  high while the state is RUN.
- done  output  1  high while the state is DONE.
- alarm  output  1  one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset values (reset=0 at an edge): IDLE; all digits 0; preset 0; prescaler 0; running, done and alarm all 0.
- Input priority at each edge: reset > load > stop > start_resume.
- load, in any state:
  - Clamp each set_* digit to its maximum: 9 for min0, sec0 and milSec0; 5 for sec1.
  - Write the clamped values to both the preset register and the digits.
  - Clear the prescaler and go to IDLE.
- start_resume:
  - IDLE or PAUSE → RUN, but only if the count is nonzero. A zero count stays in IDLE.
  - DONE → IDLE, with the digits reloaded from the preset.
  - RUN: no effect.
- stop:
  - RUN → PAUSE. The prescaler value is held, not cleared.
  - All other states: no effect.
  - If stop and start_resume are asserted together, stop wins and start_resume is ignored.
- Prescaler:
  - Counts 0 .. TICK_DIV-1 only in RUN, then wraps to 0.
  - tick = (state==RUN) && (prescaler==TICK_DIV-1).
  - Cleared on load, and on the IDLE→RUN transition.
- Decrement on tick uses a borrow chain milSec0 → sec0 → sec1 → min0:
  - A digit at 0 that receives a borrow wraps to its maximum (9, 9, 5, 9 respectively) and borrows from the next digit.
  - A digit above 0 decrements by 1 and does not borrow.
- Terminal condition: a tick with count 0:00.1 sets the count to 0:00.0 and moves to DONE on the same edge. The count never wraps below zero.
- DONE holds the digits at zero.

## Timing
- The start_resume edge moves the state to RUN. The first decrement happens TICK_DIV edges later.
- With TICK_DIV=1, the count changes on every edge in RUN.
- running and done are registered state decodes and change on the same edge as the state.
- alarm is high for exactly the one cycle after the edge that enters DONE.
- load takes effect at the next edge. The digits show the clamped preset one cycle after the load cycle.
- A reset asserted mid-run forces the reset values at the next edge, with no partial decrement.

## Structure
- Shared package `watch_pkg` holds:
  - the state enum (IDLE/RUN/PAUSE/DONE);
  - digit maximum constants (DIG9_MAX=9, DIG6_MAX=5);
  - the BCD digit typedef (4 bits).
- Sub-module `ModNDownCounter`, with parameter MAX:
  - inputs: en (borrow-in), load, load value;
  - outputs: digit, borrow-out, zero flag.
- Top level instantiates four ModNDownCounter: MAX=9 for milSec0, sec0 and min0; MAX=5 for sec1.
- The prescaler, the FSM and the preset register live in the top level.

## Test plan
- Reset, then load 0:01.2 with TICK_DIV=1, then pulse start_resume:
  - the count goes 0:01.1, 0:01.0, 0:00.9 … 0:00.0 over 12 edges;
  - done=1, and alarm is high for exactly 1 cycle.
- Load 1:00.0 and run 1 tick → 0:59.9, exercising the full borrow chain through all four digits.
- Load with set_sec1=7 and set_milSec0=12 → the digits read sec1=5 and milSec0=9.
- With TICK_DIV=4:
  - start, run 6 cycles, stop for 10 cycles with no change, then resume;
  - the second decrement lands 2 edges after resume (prescaler value retained).
- start_resume and stop together in PAUSE → stays in PAUSE. start_resume with count 0:00.0 in IDLE → stays in IDLE, running=0.
- In DONE, start_resume → IDLE with the preset restored. Reset asserted mid-RUN → all outputs 0 at the next edge.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch controller timers.
package watch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam bcd_t DIG9_MAX = 4'd9;
  localparam bcd_t DIG6_MAX = 4'd5;

  // Saturate a preset digit so out-of-range BCD never enters the counters.
  function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t max_v);
    return (d > max_v) ? max_v : d;
  endfunction

endpackage

// File: rtl/ModNDownCounter.sv
// One BCD digit of the countdown: loadable, wraps 0 -> MAX on a borrow-in.
module ModNDownCounter
  import watch_pkg::*;
#(
  parameter bcd_t MAX = DIG9_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       borrow_out,
  output logic       zero
);

  assign zero       = (digit == 4'd0);
  assign borrow_out = en && zero;

  // Digit register: load has priority over the borrow-in decrement.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (en) begin
      digit <= zero ? MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// M:SS.t countdown timer with clock-enable prescaler, done level and alarm pulse.
//
// state | meaning
// IDLE  | preset loaded or re-armed, waiting for start_resume
// RUN   | counting down one digit step per prescaler tick
// PAUSE | stopped mid-count, prescaler phase retained
// DONE  | reached 0:00.0, digits held at zero
module countdown_timer
  import watch_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] set_min0,
  input  logic [3:0] set_sec1,
  input  logic [3:0] set_sec0,
  input  logic [3:0] set_milSec0,
  input  logic       start_resume,
  input  logic       stop,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [3:0] milSec0,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  bcd_t          pre_min0, pre_sec1, pre_sec0, pre_ms0;
  bcd_t          clp_min0, clp_sec1, clp_sec0, clp_ms0;
  bcd_t          ld_min0, ld_sec1, ld_sec0, ld_ms0;
  logic          tick, dec, rearm, ctr_load;
  logic          count_zero, count_one;
  logic          b_ms, b_s0, b_s1, min_borrow_unused;
  logic          z_ms, z_s0, z_s1, z_m;

  assign clp_min0 = clamp_digit(set_min0, DIG9_MAX);
  assign clp_sec1 = clamp_digit(set_sec1, DIG6_MAX);
  assign clp_sec0 = clamp_digit(set_sec0, DIG9_MAX);
  assign clp_ms0  = clamp_digit(set_milSec0, DIG9_MAX);

  // A stop on the tick edge wins: the count freezes along with the prescaler.
  assign tick     = (state == RUN) && (presc == PRESC_LAST);
  assign dec      = tick && !load && !stop;
  assign rearm    = (state == DONE) && start_resume && !load && !stop;
  assign ctr_load = load || rearm;

  assign ld_min0 = load ? clp_min0 : pre_min0;
  assign ld_sec1 = load ? clp_sec1 : pre_sec1;
  assign ld_sec0 = load ? clp_sec0 : pre_sec0;
  assign ld_ms0  = load ? clp_ms0  : pre_ms0;

  assign count_zero = z_m && z_s1 && z_s0 && z_ms;
  assign count_one  = z_m && z_s1 && z_s0 && (milSec0 == 4'd1);

  ModNDownCounter #(.MAX(DIG9_MAX)) u_ms0 (
    .clk(clk), .reset(reset), .en(dec), .load(ctr_load), .load_val(ld_ms0),
    .digit(milSec0), .borrow_out(b_ms), .zero(z_ms)
  );

  ModNDownCounter #(.MAX(DIG9_MAX)) u_sec0 (
    .clk(clk), .reset(reset), .en(b_ms), .load(ctr_load), .load_val(ld_sec0),
    .digit(sec0), .borrow_out(b_s0), .zero(z_s0)
  );

  ModNDownCounter #(.MAX(DIG6_MAX)) u_sec1 (
    .clk(clk), .reset(reset), .en(b_s0), .load(ctr_load), .load_val(ld_sec1),
    .digit(sec1), .borrow_out(b_s1), .zero(z_s1)
  );

  // The count never goes below zero in RUN, so the top borrow never fires.
  ModNDownCounter #(.MAX(DIG9_MAX)) u_min0 (
    .clk(clk), .reset(reset), .en(b_s1), .load(ctr_load), .load_val(ld_min0),
    .digit(min0), .borrow_out(min_borrow_unused), .zero(z_m)
  );

  // Control FSM with prescaler, preset register and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      presc    <= '0;
      pre_min0 <= 4'd0;
      pre_sec1 <= 4'd0;
      pre_sec0 <= 4'd0;
      pre_ms0  <= 4'd0;
      running  <= 1'b0;
      done     <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      alarm <= 1'b0;
      if (load) begin
        pre_min0 <= clp_min0;
        pre_sec1 <= clp_sec1;
        pre_sec0 <= clp_sec0;
        pre_ms0  <= clp_ms0;
        presc    <= '0;
        state    <= IDLE;
        running  <= 1'b0;
        done     <= 1'b0;
      end else if (stop) begin
        if (state == RUN) begin
          state   <= PAUSE;
          running <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start_resume && !count_zero) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          PAUSE: begin
            if (start_resume && !count_zero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && count_one) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
              alarm   <= 1'b1;
            end
          end
          DONE: begin
            if (start_resume) begin
              state <= IDLE;
              done  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at TICK_DIV=1 and TICK_DIV=4.
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] set_min0, set_sec1, set_sec0, set_milSec0;
  logic       start_resume;
  logic       stop;

  logic [3:0] a_min0, a_sec1, a_sec0, a_ms0;
  logic       a_running, a_done, a_alarm;
  logic [3:0] b_min0, b_sec1, b_sec0, b_ms0;
  logic       b_running, b_done, b_alarm;

  int n_cmp = 0;
  int n_err = 0;

  countdown_timer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .load(load),
    .set_min0(set_min0), .set_sec1(set_sec1), .set_sec0(set_sec0),
    .set_milSec0(set_milSec0), .start_resume(start_resume), .stop(stop),
    .min0(a_min0), .sec1(a_sec1), .sec0(a_sec0), .milSec0(a_ms0),
    .running(a_running), .done(a_done), .alarm(a_alarm)
  );

  countdown_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .load(load),
    .set_min0(set_min0), .set_sec1(set_sec1), .set_sec0(set_sec0),
    .set_milSec0(set_milSec0), .start_resume(start_resume), .stop(stop),
    .min0(b_min0), .sec1(b_sec1), .sec0(b_sec0), .milSec0(b_ms0),
    .running(b_running), .done(b_done), .alarm(b_alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (observed running, expected finished)");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt1();
    return {a_min0, a_sec1, a_sec0, a_ms0};
  endfunction

  function automatic logic [15:0] cnt4();
    return {b_min0, b_sec1, b_sec0, b_ms0};
  endfunction

  function automatic logic [15:0] flg1();
    return {13'd0, a_running, a_done, a_alarm};
  endfunction

  function automatic logic [15:0] flg4();
    return {13'd0, b_running, b_done, b_alarm};
  endfunction

  task automatic do_load(input logic [3:0] m, input logic [3:0] s1,
                         input logic [3:0] s0, input logic [3:0] t);
    load = 1'b1; set_min0 = m; set_sec1 = s1; set_sec0 = s0; set_milSec0 = t;
    step();
    load = 1'b0;
  endtask

  initial begin
    int v;
    reset = 1'b0; load = 1'b0; start_resume = 1'b0; stop = 1'b0;
    set_min0 = 4'd0; set_sec1 = 4'd0; set_sec0 = 4'd0; set_milSec0 = 4'd0;

    step();
    chk("reset_count", cnt1(), 16'h0000);
    chk("reset_flags", flg1(), 16'h0000);
    chk("reset_count4", cnt4(), 16'h0000);
    reset = 1'b1;

    // 0:01.2 countdown at one decrement per edge
    do_load(4'd0, 4'd0, 4'd1, 4'd2);
    chk("load_012", cnt1(), 16'h0012);
    chk("load_flags", flg1(), 16'h0000);
    start_resume = 1'b1;
    step();
    start_resume = 1'b0;
    chk("start_count", cnt1(), 16'h0012);
    chk("start_flags", flg1(), 16'h0004);
    for (int i = 1; i <= 11; i++) begin
      step();
      v = 12 - i;
      chk("countdown", cnt1(), {8'h00, 4'(v / 10), 4'(v % 10)});
      chk("countdown_flags", flg1(), 16'h0004);
    end
    step();
    chk("zero_count", cnt1(), 16'h0000);
    chk("done_alarm", flg1(), 16'h0003);
    step();
    chk("done_hold", cnt1(), 16'h0000);
    chk("alarm_one_cycle", flg1(), 16'h0002);

    // re-arm from DONE restores the preset
    start_resume = 1'b1;
    step();
    start_resume = 1'b0;
    chk("rearm_count", cnt1(), 16'h0012);
    chk("rearm_flags", flg1(), 16'h0000);

    // full borrow chain 1:00.0 -> 0:59.9
    do_load(4'd1, 4'd0, 4'd0, 4'd0);
    chk("load_1000", cnt1(), 16'h1000);
    start_resume = 1'b1;
    step();
    start_resume = 1'b0;
    step();
    chk("borrow_chain", cnt1(), 16'h0599);

    // pause, then simultaneous stop+start in PAUSE
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_count", cnt1(), 16'h0599);
    chk("stop_flags", flg1(), 16'h0000);
    step();
    step();
    chk("pause_hold", cnt1(), 16'h0599);
    stop = 1'b1; start_resume = 1'b1;
    step();
    stop = 1'b0; start_resume = 1'b0;
    chk("stop_wins_count", cnt1(), 16'h0599);
    chk("stop_wins_flags", flg1(), 16'h0000);
    start_resume = 1'b1;
    step();
    start_resume = 1'b0;
    chk("resume_flags", flg1(), 16'h0004);
    chk("resume_count", cnt1(), 16'h0599);
    step();
    chk("resume_dec", cnt1(), 16'h0598);

    // clamp of out-of-range preset digits
    do_load(4'hF, 4'd7, 4'd3, 4'hC);
    chk("clamp", cnt1(), 16'h9539);
    chk("clamp_flags", flg1(), 16'h0000);

    // zero count does not start
    do_load(4'd0, 4'd0, 4'd0, 4'd0);
    start_resume = 1'b1;
    step();
    start_resume = 1'b0;
    chk("zero_start_flags", flg1(), 16'h0000);
    chk("zero_start_count", cnt1(), 16'h0000);

    // TICK_DIV=4: prescaler phase retained across a pause
    do_load(4'd0, 4'd0, 4'd0, 4'd5);
    chk("d4_load", cnt4(), 16'h0005);
    start_resume = 1'b1;
    step();
    start_resume = 1'b0;
    chk("d4_start_flags", flg4(), 16'h0004);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("d4_run", cnt4(), (k >= 4) ? 16'h0004 : 16'h0005);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("d4_pause_flags", flg4(), 16'h0000);
    for (int k = 0; k < 9; k++) begin
      step();
      chk("d4_pause_hold", cnt4(), 16'h0004);
    end
    start_resume = 1'b1;
    step();
    start_resume = 1'b0;
    chk("d4_resume_flags", flg4(), 16'h0004);
    chk("d4_resume_count", cnt4(), 16'h0004);
    step();
    chk("d4_resume_plus1", cnt4(), 16'h0004);
    step();
    chk("d4_second_dec", cnt4(), 16'h0003);

    // reset mid-run
    reset = 1'b0;
    step();
    chk("midrun_reset_count", cnt4(), 16'h0000);
    chk("midrun_reset_flags", flg4(), 16'h0000);
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
